xsleena_audio_mixer: RTL and testbench

- Downstream consumer of the sound CPU block's two YM2203 outputs (snd1/snd2 with their sample strobes).
- Holds the latest sample from each OPN and applies a per-chip gain.
- Sums the two channels with saturation and an optional one-pole low-pass filter.
- Presents one signed 16-bit mono stream with a valid pulse to the MiSTer audio path.

---
 rtl/xsleena_audio_mixer_if.sv | 20 ++
 rtl/xsleena_audio_mixer.sv | 108 ++++++++++
 tb/tb_xsleena_audio_mixer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/xsleena_audio_mixer_if.sv
// Mono audio stream bundle between the sound CPU outputs and the mixer.
// The master drives the two OPN sample streams; the slave returns the mix.
interface xsleena_audio_mixer_if;
    logic signed [15:0] snd1;
    logic               sample1;
    logic signed [15:0] snd2;
    logic               sample2;
    logic signed [15:0] snd_out;
    logic               snd_valid;

    modport master (
        output snd1, sample1, snd2, sample2,
        input  snd_out, snd_valid
    );

    modport slave (
        input  snd1, sample1, snd2, sample2,
        output snd_out, snd_valid
    );
endinterface

// File: rtl/xsleena_audio_mixer.sv
// Two-OPN mixer: hold, per-chip Q4.4 gain, saturating sum,
// optional one-pole low-pass, signed 16-bit mono output with valid pulse.
module xsleena_audio_mixer #(
    parameter int GAIN_W    = 8,
    parameter int LPF_SHIFT = 0,
    parameter int CLIPCNT_W = 8
) (
    input  logic                 clk,
    input  logic                 RSTn,
    xsleena_audio_mixer_if.slave aud,
    input  logic [GAIN_W-1:0]    gain1,
    input  logic [GAIN_W-1:0]    gain2,
    input  logic                 mute,
    input  logic                 pause_rq,
    input  logic                 clip_clr,
    output logic [CLIPCNT_W-1:0] clip_cnt
);

    logic run;

    logic signed [15:0] hold1, hold2;
    logic               v0, v1, v2, v3, v4;
    logic signed [23:0] p1, p2;
    logic signed [24:0] s;
    logic signed [15:0] x3, y;

    logic signed [23:0] h1x, h2x, g1x, g2x, m1, m2;
    logic signed [24:0] sum;
    logic signed [20:0] xs;
    logic               sat_hi, sat_lo;
    logic signed [15:0] x_sat;
    logic signed [16:0] d;
    logic signed [15:0] y_next;

    assign run = ~pause_rq;

    always_comb begin
        h1x = {{8{hold1[15]}}, hold1};
        h2x = {{8{hold2[15]}}, hold2};
        g1x = {{(24-GAIN_W){1'b0}}, gain1};
        g2x = {{(24-GAIN_W){1'b0}}, gain2};
        m1  = h1x * g1x;
        m2  = h2x * g2x;
        sum = {p1[23], p1} + {p2[23], p2};
        // Dropping the Q4.4 fraction floors toward minus infinity
        xs     = 21'(s >>> 4);
        sat_hi = xs > 21'sd32767;
        sat_lo = xs < -21'sd32768;
        if (sat_hi)
            x_sat = 16'sh7fff;
        else if (sat_lo)
            x_sat = 16'sh8000;
        else
            x_sat = 16'(xs);
        d = {x3[15], x3} - {y[15], y};
        // Step toward x never overshoots, so 16 bits always suffice
        if (LPF_SHIFT == 0)
            y_next = x3;
        else
            y_next = y + 16'(d >>> LPF_SHIFT);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            hold1 <= '0;
            hold2 <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            v4    <= 1'b0;
            p1    <= '0;
            p2    <= '0;
            s     <= '0;
            x3    <= '0;
            y     <= '0;
        end else if (run) begin
            if (aud.sample1)
                hold1 <= aud.snd1;
            if (aud.sample2)
                hold2 <= aud.snd2;
            v0 <= aud.sample1 | aud.sample2;
            p1 <= m1;
            p2 <= m2;
            v1 <= v0;
            s  <= mute ? '0 : sum;
            v2 <= v1;
            x3 <= x_sat;
            v3 <= v2;
            if (v3)
                y <= y_next;
            v4 <= v3;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            clip_cnt <= '0;
        else if (clip_clr)
            clip_cnt <= '0;
        else if (run && v2 && (sat_hi || sat_lo) && !(&clip_cnt))
            clip_cnt <= clip_cnt + 1'b1;
    end

    assign aud.snd_out   = y;
    assign aud.snd_valid = v4 & run;

endmodule

// File: tb/tb_xsleena_audio_mixer.sv
// Scoreboard bench for xsleena_audio_mixer: instance A without filter,
// instance B with LPF_SHIFT=1; strobes are steered to one instance by sel.
module tb_xsleena_audio_mixer;

    logic clk = 1'b0;
    logic RSTn = 1'b0;
    always #5 clk = ~clk;

    logic signed [15:0] snd1 = '0, snd2 = '0;
    logic sample1 = 1'b0, sample2 = 1'b0, sel = 1'b0;
    logic [7:0] gain1 = 8'h10, gain2 = 8'h10;
    logic mute = 1'b0, pause_rq = 1'b0, clip_clr = 1'b0;
    logic [7:0] clip_a, clip_b;

    xsleena_audio_mixer_if ia ();
    xsleena_audio_mixer_if ib ();

    assign ia.snd1    = snd1;
    assign ia.snd2    = snd2;
    assign ia.sample1 = sample1 & ~sel;
    assign ia.sample2 = sample2 & ~sel;
    assign ib.snd1    = snd1;
    assign ib.snd2    = snd2;
    assign ib.sample1 = sample1 & sel;
    assign ib.sample2 = sample2 & sel;

    xsleena_audio_mixer #(.GAIN_W(8), .LPF_SHIFT(0), .CLIPCNT_W(8)) dut_a (
        .clk(clk), .RSTn(RSTn), .aud(ia),
        .gain1(gain1), .gain2(gain2), .mute(mute),
        .pause_rq(pause_rq), .clip_clr(clip_clr), .clip_cnt(clip_a)
    );

    xsleena_audio_mixer #(.GAIN_W(8), .LPF_SHIFT(1), .CLIPCNT_W(8)) dut_b (
        .clk(clk), .RSTn(RSTn), .aud(ib),
        .gain1(gain1), .gain2(gain2), .mute(mute),
        .pause_rq(pause_rq), .clip_clr(clip_clr), .clip_cnt(clip_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int n_tests = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        exp_t e;
        if (ia.snd_valid) begin
            n_tests++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL mon_a: unexpected snd_valid, snd_out=%0d cyc=%0d", ia.snd_out, cyc);
            end else begin
                e = qa.pop_front();
                if (int'(ia.snd_out) != e.val || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL mon_a: got %0d at cyc %0d, need %0d at cyc %0d", ia.snd_out, cyc, e.val, e.due);
                end
            end
        end
        if (ib.snd_valid) begin
            n_tests++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL mon_b: unexpected snd_valid, snd_out=%0d cyc=%0d", ib.snd_out, cyc);
            end else begin
                e = qb.pop_front();
                if (int'(ib.snd_out) != e.val || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL mon_b: got %0d at cyc %0d, need %0d at cyc %0d", ib.snd_out, cyc, e.val, e.due);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit b, input int due, input int val);
        exp_t e;
        e.due = due;
        e.val = val;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    // Called #1 after a posedge; the strobe is sampled at the next edge
    task automatic strobe(input bit s1, input bit s2, input int v1, input int v2,
                          input bit b, input bit has_exp, input int ev);
        sel     = b;
        snd1    = 16'(v1);
        snd2    = 16'(v2);
        sample1 = s1;
        sample2 = s2;
        if (has_exp) push(b, cyc + 5, ev);
        tick(1);
        sample1 = 1'b0;
        sample2 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
            tick(1);
            t++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d/%0d events never produced snd_valid", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_out_a", ia.snd_out, 0);
        check("rst_valid_a", ia.snd_valid, 0);
        check("rst_clip_a", clip_a, 0);
        check("rst_out_b", ib.snd_out, 0);
        RSTn = 1'b1;
        tick(2);

        strobe(1, 1, 1000, 2000, 0, 1, 3000);
        drain();
        check("unity_clip", clip_a, 0);

        gain1 = 8'h08;
        strobe(1, 0, 1000, 0, 0, 1, 2500);
        strobe(1, 0, -1, 0, 0, 1, 1999);
        drain();
        gain1 = 8'h10;

        strobe(1, 1, 30000, 30000, 0, 1, 32767);
        drain();
        check("clip_pos", clip_a, 1);
        strobe(1, 1, -30000, -30000, 0, 1, -32768);
        drain();
        check("clip_neg", clip_a, 2);
        clip_clr = 1'b1;
        tick(1);
        clip_clr = 1'b0;
        check("clip_clr", clip_a, 0);
        for (int i = 0; i < 300; i++)
            strobe(1, 1, 30000, 30000, 0, 1, 32767);
        drain();
        check("clip_sat", clip_a, 255);
        check("clip_b_idle", clip_b, 0);

        strobe(1, 1, 0, 0, 0, 1, 0);
        strobe(1, 0, 100, 0, 0, 1, 100);
        strobe(1, 0, 200, 0, 0, 1, 200);
        strobe(1, 0, 300, 0, 0, 1, 300);
        drain();

        // In-flight event stretched by a 3-cycle pause
        sel     = 1'b0;
        snd1    = 16'sd400;
        sample1 = 1'b1;
        push(0, cyc + 8, 400);
        tick(1);
        sample1  = 1'b0;
        pause_rq = 1'b1;
        tick(3);
        pause_rq = 1'b0;
        drain();

        strobe(1, 0, 1000, 0, 1, 1, 500);
        strobe(1, 0, 1000, 0, 1, 1, 750);
        strobe(1, 0, 1000, 0, 1, 1, 875);
        drain();
        mute = 1'b1;
        strobe(1, 0, 1000, 0, 1, 1, 437);
        drain();
        mute = 1'b0;

        pause_rq = 1'b1;
        tick(1);
        sel     = 1'b1;
        snd1    = 16'sd5000;
        sample1 = 1'b1;
        tick(2);
        sample1 = 1'b0;
        tick(8);
        pause_rq = 1'b0;
        tick(2);
        check("pause_out_b", ib.snd_out, 437);
        strobe(0, 1, 0, 0, 1, 1, 718);
        drain();
        check("pause_out_a", ia.snd_out, 400);

        strobe(1, 0, 1234, 0, 0, 0, 0);
        tick(1);
        RSTn = 1'b0;
        #1;
        check("arst_out_a", ia.snd_out, 0);
        check("arst_valid_a", ia.snd_valid, 0);
        check("arst_out_b", ib.snd_out, 0);
        tick(2);
        RSTn = 1'b1;
        tick(12);
        check("arst_clip_a", clip_a, 0);
        check("arst_out_after", ia.snd_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
